ahb_lite_sram_slave: RTL and testbench

- AHB-Lite responder: a word-organised SRAM slave that completes transfers issued by core_wrapper.
- Sits on one HSEL output of ahb_interconnect. Its hrdata, hreadyout and hresp return to the interconnect response mux.
- Inserts configurable wait states and byte-lane writes, and gives the two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_lite_sram_slave.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: word-organised SRAM responder on an AHB-Lite bus.
//
// Completes one transfer at a time. Each legal transfer gets WAIT_STATES
// hreadyout-low cycles, then a completing cycle with hreadyout=1. Illegal
// transfers get the two-cycle ERROR response. Byte-lane writes are little-endian.
// hrdata always returns the full 32-bit word. Addresses alias modulo
// 4*2^ADDR_WIDTH bytes.
//
// Optional feature: define AHB_SLV_PROT_EN to make a non-privileged write
// (hprot[1]=0) to a word below PROT_WORDS illegal. Reads are never blocked.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   hsel, hready      slave select, bus-level ready
//   haddr, htrans     byte address, transfer type (htrans[1] = NONSEQ/SEQ)
//   hwrite, hsize     direction, size (byte/half/word)
//   hprot             protection (bit1 = privileged)
//   hwdata            write data, data phase
//   hrdata            registered read data
//   hreadyout, hresp  slave ready, response (0 OKAY, 1 ERROR)

module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PROT_WORDS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam bit          HasWait  = (WAIT_STATES > 0);
  localparam logic [3:0]  WaitInit = HasWait ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  pend_q, pend_d;     // legal transfer in its data phase
  logic [3:0]            wcnt_q, wcnt_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;

  logic [31:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] a_word;
  logic [1:0]            a_off;
  logic                  accept;
  logic                  a_illegal;
  logic                  commit;
  logic [3:0]            commit_be;
  logic [31:0]           fwd_word;

  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign a_word = haddr[ADDR_WIDTH+1:2];
  assign a_off  = haddr[1:0];
  // hreadyout_q gates acceptance so nothing is taken while a transfer is stalled.
  assign accept = hsel & hready & htrans[1] & hreadyout_q;

  always_comb begin
    a_illegal = 1'b0;
    case (hsize)
      3'b000:  a_illegal = 1'b0;
      3'b001:  a_illegal = a_off[0];
      3'b010:  a_illegal = |a_off;
      default: a_illegal = 1'b1;
    endcase
`ifdef AHB_SLV_PROT_EN
    if (hwrite && !hprot[1] && (32'(a_word) < PROT_WORDS)) begin
      a_illegal = 1'b1;
    end
`endif
  end

  // The completing cycle of a legal write is an StIdle cycle with pend_q set.
  assign commit    = (state_q == StIdle) && pend_q && write_q;
  assign commit_be = lane_mask(size_q, off_q);

  // Zero-wait read of the word a completing write is updating sees the new bytes.
  always_comb begin
    fwd_word = mem[a_word];
    if (commit && (word_q == a_word)) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_be[b]) fwd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    off_d       = off_q;
    size_d      = size_q;
    write_d     = write_q;
    pend_d      = pend_q;
    wcnt_d      = wcnt_q;
    hrdata_d    = hrdata_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    case (state_q)
      StWait: begin
        if (wcnt_q == 4'd0) begin
          state_d     = StIdle;
          hreadyout_d = 1'b1;
          if (!write_q) hrdata_d = mem[word_q];
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StErr1: begin
        state_d     = StErr2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        // StIdle or StErr2: any data phase completes now; a new one may start.
        state_d     = StIdle;
        pend_d      = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept) begin
          word_d  = a_word;
          off_d   = a_off;
          size_d  = hsize[1:0];
          write_d = hwrite;
          if (a_illegal) begin
            state_d     = StErr1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            pend_d = 1'b1;
            if (HasWait) begin
              state_d     = StWait;
              hreadyout_d = 1'b0;
              wcnt_d      = WaitInit;
            end else if (!hwrite) begin
              hrdata_d = fwd_word;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      pend_q      <= 1'b0;
      wcnt_q      <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      pend_q      <= pend_d;
      wcnt_q      <= wcnt_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // SRAM array: not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_be[b]) mem[word_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  logic unused_bits;
`ifdef AHB_SLV_PROT_EN
  assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0], hprot[3:2], hprot[0]};
`else
  assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0], hprot, PROT_WORDS};
`endif

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with WAIT_STATES=1 (dut0) and one
// with WAIT_STATES=0 (dut1) run the same operation list. Drivers push the
// expected response of each accepted transfer; a negedge monitor pops and
// compares whenever a data phase completes.

module tb_ahb_lite_sram_slave;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  prot;
    int          gap;
  } op_t;

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        hsel_v      [2];
  logic [31:0] haddr_v     [2];
  logic [1:0]  htrans_v    [2];
  logic        hwrite_v    [2];
  logic [2:0]  hsize_v     [2];
  logic [3:0]  hprot_v     [2];
  logic [31:0] hwdata_v    [2];
  logic        hready_v    [2];
  logic [31:0] hrdata_v    [2];
  logic        hreadyout_v [2];
  logic        hresp_v     [2];

  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1), .PROT_WORDS(64)) u_dut_ws1 (
    .clk(clk), .reset(reset), .hsel(hsel_v[0]), .haddr(haddr_v[0]), .htrans(htrans_v[0]),
    .hwrite(hwrite_v[0]), .hsize(hsize_v[0]), .hprot(hprot_v[0]), .hwdata(hwdata_v[0]),
    .hready(hready_v[0]), .hrdata(hrdata_v[0]), .hreadyout(hreadyout_v[0]), .hresp(hresp_v[0])
  );

  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .PROT_WORDS(64)) u_dut_ws0 (
    .clk(clk), .reset(reset), .hsel(hsel_v[1]), .haddr(haddr_v[1]), .htrans(htrans_v[1]),
    .hwrite(hwrite_v[1]), .hsize(hsize_v[1]), .hprot(hprot_v[1]), .hwdata(hwdata_v[1]),
    .hready(hready_v[1]), .hrdata(hrdata_v[1]), .hreadyout(hreadyout_v[1]), .hresp(hresp_v[1])
  );

  // Single slave on the bus: bus ready is the slave's own ready.
  assign hready_v[0] = hreadyout_v[0];
  assign hready_v[1] = hreadyout_v[1];

  int n_checks = 0;
  int n_errors = 0;

  op_t         ops [$];
  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [31:0] mem_m [2][1024];
  bit          dp_v [2];
  int          wcnt_v [2];

  function automatic int ws(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic void check(string name, int k, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, req);
    end
  endfunction

  function automatic void fail_now(string name, int k);
    n_checks++;
    n_errors++;
    $display("FAIL %s dut%0d: bound expired", name, k);
  endfunction

  // Reference model: AHB rules applied to a plain word array.
  function automatic void push_exp(int k, op_t o);
    exp_t e;
    int   word, off, nb;
    bit   err;
    word = int'(o.addr[11:2]);
    off  = int'(o.addr[1:0]);
    err  = (o.size > 3'd2);
    nb   = err ? 0 : (1 << o.size);
    if (!err && ((off % nb) != 0)) err = 1'b1;
`ifdef AHB_SLV_PROT_EN
    if (o.write && !o.prot[1] && (word < 64)) err = 1'b1;
`endif
    if (!err && o.write) begin
      for (int b = off; b < off + nb; b++) mem_m[k][word][8*b +: 8] = o.wdata[8*b +: 8];
    end
    e.is_err = err;
    e.is_rd  = !o.write;
    e.rdata  = mem_m[k][word];
    e.waits  = err ? 1 : ws(k);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic bit peek_exp(int k, output exp_t e);
    if (k == 0 && q0.size() > 0) begin e = q0[0]; return 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1[0]; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit pop_exp(int k, output exp_t e);
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void mon_step(int k);
    exp_t e;
    bit   acc;
    if (reset === 1'b1) begin
      dp_v[k]   = 1'b0;
      wcnt_v[k] = 0;
      return;
    end
    acc = (hsel_v[k] === 1'b1) && (hready_v[k] === 1'b1) && (htrans_v[k][1] === 1'b1);
    if (dp_v[k]) begin
      if (hreadyout_v[k] !== 1'b1) begin
        wcnt_v[k]++;
        if (peek_exp(k, e)) check("hresp_wait", k, 32'(hresp_v[k]), 32'(e.is_err));
      end else begin
        if (pop_exp(k, e)) begin
          check("wait_cycles", k, 32'(wcnt_v[k]), 32'(e.waits));
          check("hresp", k, 32'(hresp_v[k]), 32'(e.is_err));
          if (e.is_rd && !e.is_err) check("hrdata", k, hrdata_v[k], e.rdata);
        end else begin
          fail_now("unexpected_completion", k);
        end
        dp_v[k]   = 1'b0;
        wcnt_v[k] = 0;
      end
    end
    if (acc) dp_v[k] = 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon_step(k);
  end

  function automatic void set_idle(int k);
    hsel_v[k]   = 1'($urandom_range(0, 1));
    htrans_v[k] = 2'($urandom_range(0, 1));
    haddr_v[k]  = $urandom();
    hwrite_v[k] = 1'($urandom_range(0, 1));
    hsize_v[k]  = 3'($urandom_range(0, 2));
    hprot_v[k]  = 4'($urandom_range(0, 15));
  endfunction

  function automatic void present(int k, op_t o);
    hsel_v[k]   = 1'b1;
    htrans_v[k] = {1'b1, 1'($urandom_range(0, 1))};
    haddr_v[k]  = o.addr;
    hwrite_v[k] = o.write;
    hsize_v[k]  = o.size;
    hprot_v[k]  = o.prot;
  endfunction

  task automatic drive(input int k);
    int nxt, ap, gap, stall;
    bit acc;
    nxt = 0; ap = -1; gap = 0; stall = 0;
    while (nxt < ops.size() || ap >= 0) begin
      if (ap < 0 && nxt < ops.size()) begin
        if (gap < ops[nxt].gap) begin
          gap++;
        end else begin
          ap  = nxt;
          nxt++;
          gap = 0;
          present(k, ops[ap]);
        end
      end
      if (ap < 0) set_idle(k);
      @(negedge clk);
      acc = (hsel_v[k] === 1'b1) && (hready_v[k] === 1'b1) && (htrans_v[k][1] === 1'b1);
      @(posedge clk);
      #1;
      if (acc) begin
        hwdata_v[k] = ops[ap].wdata;
        push_exp(k, ops[ap]);
        ap    = -1;
        stall = 0;
      end else if (ap >= 0) begin
        stall++;
        if (stall > 40) begin
          fail_now("accept_timeout", k);
          break;
        end
      end
    end
    set_idle(k);
  endtask

  function automatic bit busy();
    return (q0.size() > 0) || (q1.size() > 0) || dp_v[0] || dp_v[1];
  endfunction

  task automatic run_ops();
    fork
      drive(0);
      drive(1);
    join
    for (int t = 0; t < 50 && busy(); t++) @(negedge clk);
    if (busy()) begin
      fail_now("drain_timeout", 0);
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void add_op(logic [31:0] addr, logic write, logic [2:0] size,
                                 logic [31:0] wdata, logic [3:0] prot, int gap);
    op_t o;
    o.addr = addr; o.write = write; o.size = size;
    o.wdata = wdata; o.prot = prot; o.gap = gap;
    ops.push_back(o);
  endfunction

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_idle(k);
      hsel_v[k]   = 1'b0;
      hwdata_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_hreadyout", k, 32'(hreadyout_v[k]), 32'd1);
      check("reset_hresp", k, 32'(hresp_v[k]), 32'd0);
      check("reset_hrdata", k, hrdata_v[k], 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Known contents everywhere so every readback has a defined expectation.
    ops.delete();
    for (int w = 0; w < 1024; w++) add_op(32'(w * 4), 1'b1, 3'd2, 32'h0, 4'h2, 0);
    run_ops();

    // Directed transfers.
    ops.delete();
    add_op(32'h010, 1'b1, 3'd2, 32'hDEADBEEF, 4'h2, 0);
    add_op(32'h010, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h013, 1'b1, 3'd0, 32'hAA000000, 4'h2, 1);
    add_op(32'h010, 1'b1, 3'd1, 32'h00001234, 4'h2, 0);
    add_op(32'h010, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h020, 1'b1, 3'd2, 32'h55667788, 4'h2, 2);
    add_op(32'h020, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h006, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h006, 1'b1, 3'd2, 32'hCAFEF00D, 4'h2, 0);
    add_op(32'h004, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h012, 1'b1, 3'd1, 32'hBEEF0000, 4'h2, 0);
    add_op(32'h010, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h011, 1'b1, 3'd1, 32'h77777777, 4'h2, 0);
    add_op(32'h010, 1'b0, 3'd3, 32'h0, 4'h2, 0);
    add_op(32'h010, 1'b0, 3'd2, 32'h0, 4'h2, 1);
    add_op(32'h040, 1'b1, 3'd2, 32'h0BADBAD0, 4'h0, 0);
    add_op(32'h040, 1'b0, 3'd2, 32'h0, 4'h0, 0);
    add_op(32'h040, 1'b1, 3'd2, 32'h600DF00D, 4'h2, 0);
    add_op(32'h040, 1'b0, 3'd2, 32'h0, 4'h0, 0);
    add_op(32'h100, 1'b1, 3'd2, 32'h12345678, 4'h0, 0);
    add_op(32'h100, 1'b0, 3'd2, 32'h0, 4'h0, 0);
    add_op(32'hFFFFF050, 1'b1, 3'd2, 32'hA1A5A1A5, 4'h2, 0);
    add_op(32'h050, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    add_op(32'h030, 1'b1, 3'd2, 32'h0, 4'h2, 0);
    run_ops();

    // Reset in the wait cycle of a write on dut0 abandons it.
    hsel_v[0]   = 1'b1;
    haddr_v[0]  = 32'h030;
    htrans_v[0] = 2'b10;
    hwrite_v[0] = 1'b1;
    hsize_v[0]  = 3'd2;
    hprot_v[0]  = 4'h2;
    @(negedge clk);
    @(posedge clk);
    #1;
    set_idle(0);
    hsel_v[0]   = 1'b0;
    hwdata_v[0] = 32'h11111111;
    check("wait_before_reset", 0, 32'(hreadyout_v[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("midreset_hreadyout", 0, 32'(hreadyout_v[0]), 32'd1);
    check("midreset_hresp", 0, 32'(hresp_v[0]), 32'd0);
    check("midreset_hrdata", 0, hrdata_v[0], 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    ops.delete();
    add_op(32'h030, 1'b0, 3'd2, 32'h0, 4'h2, 0);
    run_ops();

    // Randomised traffic over a small word range so writes and reads collide.
    ops.delete();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      a = $urandom();
      a[11:7] = 5'b0;
      if ($urandom_range(0, 3) == 0) a[11:8] = 4'h1;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      add_op(a, 1'($urandom_range(0, 1)), sz, $urandom(), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    run_ops();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
